// File: rtl/mul4_fitness_sched_if.sv
// Bundle between the fitness scheduler, the worker pool
// and the shared 2x2 multiplier candidate datapath.
interface mul4_fitness_sched_if #(
  parameter int NREQ = 2
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   cand_sel;
  logic [15:0]     a1;
  logic [15:0]     a0;
  logic [15:0]     b1;
  logic [15:0]     b0;
  logic [15:0]     y3;
  logic [15:0]     y2;
  logic [15:0]     y1;
  logic [15:0]     y0;
  logic            busy;
  logic            done;
  logic [IW-1:0]   done_id;
  logic [6:0]      fitness;
  logic            perfect;

  modport master (
    input  req,
    input  y3,
    input  y2,
    input  y1,
    input  y0,
    output gnt,
    output cand_sel,
    output a1,
    output a0,
    output b1,
    output b0,
    output busy,
    output done,
    output done_id,
    output fitness,
    output perfect
  );

  modport slave (
    output req,
    output y3,
    output y2,
    output y1,
    output y0,
    input  gnt,
    input  cand_sel,
    input  a1,
    input  a0,
    input  b1,
    input  b0,
    input  busy,
    input  done,
    input  done_id,
    input  fitness,
    input  perfect
  );
endinterface

// File: rtl/mul4_fitness_sched.sv
// Round-robin scheduler scoring a shared bit-sliced 2x2
// multiplier candidate against the exhaustive golden product.
module mul4_fitness_sched #(
  parameter int NREQ   = 2,
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst_n,
  mul4_fitness_sched_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [15:0] OA0 = 16'hAAAA;
  localparam logic [15:0] OA1 = 16'hCCCC;
  localparam logic [15:0] OB0 = 16'hF0F0;
  localparam logic [15:0] OB1 = 16'hFF00;

  localparam logic [15:0] G0 = 16'hA0A0;
  localparam logic [15:0] G1 = 16'h6AC0;
  localparam logic [15:0] G2 = 16'h4C00;
  localparam logic [15:0] G3 = 16'h8000;

  localparam logic [3:0]    SLAST = 4'(SETTLE - 1);
  localparam logic [IW:0]   NR    = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST  = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    CMP0,
    CMP1,
    CMP2,
    CMP3,
    DONE
  } state_t;

  state_t state;
  state_t nstate;

  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] pick;
  logic          found;
  logic [IW:0]   rsum;

  logic [3:0]  scnt;
  logic [15:0] sh0;
  logic [15:0] sh1;
  logic [15:0] sh2;
  logic [15:0] sh3;

  logic [15:0] cw;
  logic [15:0] gw;
  logic [15:0] match;
  logic [4:0]  pc;
  logic [6:0]  acc;
  logic [6:0]  acc_nx;
  logic        cmp;
  logic        drive;

  logic [6:0]    fit_q;
  logic          perf_q;
  logic [IW-1:0] did_q;

  // first requester at or after ptr, wrapping at NREQ
  always_comb begin
    found = 1'b0;
    pick  = '0;
    rsum  = '0;
    for (int k = 0; k < NREQ; k++) begin
      rsum = {1'b0, ptr} + (IW+1)'(k);
      if (rsum >= NR) begin
        rsum = rsum - NR;
      end
      if (!found && bus.req[rsum]) begin
        found = 1'b1;
        pick  = rsum[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    drive  = 1'b0;
    cmp    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          nstate = DRIVE;
        end
      end
      DRIVE: begin
        drive = 1'b1;
        if (scnt == SLAST) begin
          nstate = CAPTURE;
        end
      end
      CAPTURE: begin
        drive  = 1'b1;
        nstate = CMP0;
      end
      CMP0: begin
        cmp    = 1'b1;
        nstate = CMP1;
      end
      CMP1: begin
        cmp    = 1'b1;
        nstate = CMP2;
      end
      CMP2: begin
        cmp    = 1'b1;
        nstate = CMP3;
      end
      CMP3: begin
        cmp    = 1'b1;
        nstate = DONE;
      end
      DONE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
  end

  // one popcount shared by the four compare cycles
  always_comb begin
    cw = sh0;
    gw = G0;
    unique case (1'b1)
      (state == CMP1): begin
        cw = sh1;
        gw = G1;
      end
      (state == CMP2): begin
        cw = sh2;
        gw = G2;
      end
      (state == CMP3): begin
        cw = sh3;
        gw = G3;
      end
      default: begin
        cw = sh0;
        gw = G0;
      end
    endcase
  end

  assign match = ~(cw ^ gw);

  always_comb begin
    pc = '0;
    for (int i = 0; i < 16; i++) begin
      pc = pc + {4'd0, match[i]};
    end
  end

  assign acc_nx = acc + {2'b00, pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      gidx   <= '0;
      scnt   <= '0;
      sh0    <= '0;
      sh1    <= '0;
      sh2    <= '0;
      sh3    <= '0;
      acc    <= '0;
      fit_q  <= '0;
      perf_q <= 1'b0;
      did_q  <= '0;
    end else begin
      if (state == IDLE && found) begin
        gidx <= pick;
        scnt <= '0;
        acc  <= '0;
      end
      if (state == DRIVE) begin
        scnt <= scnt + 4'd1;
      end
      if (state == CAPTURE) begin
        sh0 <= bus.y0;
        sh1 <= bus.y1;
        sh2 <= bus.y2;
        sh3 <= bus.y3;
      end
      if (cmp) begin
        acc <= acc_nx;
      end
      if (state == CMP3) begin
        fit_q  <= acc_nx;
        perf_q <= (acc_nx == 7'd64);
        did_q  <= gidx;
      end
      if (state == DONE) begin
        ptr <= (gidx == LAST) ? '0 : gidx + IW'(1);
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  assign bus.gnt = bus.busy
                 ? (NREQ'(1) << gidx)
                 : '0;

  assign bus.cand_sel = gidx;

  assign bus.a0 = drive ? OA0 : '0;
  assign bus.a1 = drive ? OA1 : '0;
  assign bus.b0 = drive ? OB0 : '0;
  assign bus.b1 = drive ? OB1 : '0;

  assign bus.done_id = did_q;
  assign bus.fitness = fit_q;
  assign bus.perfect = perf_q;

endmodule

// File: tb/tb_mul4_fitness_sched.sv
// Bench for mul4_fitness_sched: table vectors, hand sequences
// and a randomized run against a lane-level reference model.
module tb_mul4_fitness_sched;

  localparam int N0 = 3;
  localparam int S0 = 1;
  localparam int N1 = 2;
  localparam int S1 = 3;

  logic clk;
  logic rst_n;

  mul4_fitness_sched_if #(.NREQ(N0)) bus0 ();
  mul4_fitness_sched_if #(.NREQ(N1)) bus1 ();

  mul4_fitness_sched #(
    .NREQ(N0),
    .SETTLE(S0)
  ) u0 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus0)
  );

  mul4_fitness_sched #(
    .NREQ(N1),
    .SETTLE(S1)
  ) u1 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] w3;
    int          fit;
  } vec_t;

  int n_run  = 0;
  int n_fail = 0;

  logic [15:0] gold [4];
  logic [15:0] ea0, ea1, eb0, eb1;
  logic [15:0] cw0 [N0][4];
  logic [15:0] cw1 [N1][4];
  logic        drv0, drv1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // matches per lane: product bit k of a*b compared with word k
  function automatic int ref_fit(input logic [15:0] w0,
                                 input logic [15:0] w1,
                                 input logic [15:0] w2,
                                 input logic [15:0] w3);
    int m;
    int p;
    logic [15:0] w [4];
    m = 0;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    w[3] = w3;
    for (int i = 0; i < 16; i++) begin
      p = (i % 4) * (i / 4);
      for (int k = 0; k < 4; k++) begin
        if (int'(w[k][i]) == ((p >> k) & 1)) m++;
      end
    end
    return m;
  endfunction

  // the candidate is combinational and settles in one cycle
  assign drv0 = (bus0.a0 == ea0) && (bus0.a1 == ea1) &&
                (bus0.b0 == eb0) && (bus0.b1 == eb1);
  assign drv1 = (bus1.a0 == ea0) && (bus1.a1 == ea1) &&
                (bus1.b0 == eb0) && (bus1.b1 == eb1);

  always @(posedge clk) begin
    bus0.y0 <= drv0 ? cw0[bus0.cand_sel][0] : ~cw0[bus0.cand_sel][0];
    bus0.y1 <= drv0 ? cw0[bus0.cand_sel][1] : ~cw0[bus0.cand_sel][1];
    bus0.y2 <= drv0 ? cw0[bus0.cand_sel][2] : ~cw0[bus0.cand_sel][2];
    bus0.y3 <= drv0 ? cw0[bus0.cand_sel][3] : ~cw0[bus0.cand_sel][3];
    bus1.y0 <= drv1 ? cw1[bus1.cand_sel][0] : ~cw1[bus1.cand_sel][0];
    bus1.y1 <= drv1 ? cw1[bus1.cand_sel][1] : ~cw1[bus1.cand_sel][1];
    bus1.y2 <= drv1 ? cw1[bus1.cand_sel][2] : ~cw1[bus1.cand_sel][2];
    bus1.y3 <= drv1 ? cw1[bus1.cand_sel][3] : ~cw1[bus1.cand_sel][3];
  end

  task automatic set0(input int r, input logic [15:0] w0,
                      input logic [15:0] w1, input logic [15:0] w2,
                      input logic [15:0] w3);
    cw0[r][0] = w0;
    cw0[r][1] = w1;
    cw0[r][2] = w2;
    cw0[r][3] = w3;
  endtask

  task automatic rand_cand(input int r);
    int mode;
    mode = $urandom_range(0, 3);
    for (int k = 0; k < 4; k++) begin
      case (mode)
        0: cw0[r][k] = gold[k];
        1: cw0[r][k] = 16'($urandom);
        2: cw0[r][k] = gold[k] ^ (16'h1 << $urandom_range(0, 15));
        default: cw0[r][k] = ~gold[k];
      endcase
    end
  endtask

  task automatic do_reset;
    bus0.req = '0;
    bus1.req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".u0"},
        {bus0.gnt, bus0.busy, bus0.done, bus0.cand_sel,
         bus0.done_id, bus0.fitness, bus0.perfect}, '0);
    chk({nm, ".u0ops"},
        {bus0.a1, bus0.a0, bus0.b1, bus0.b0}, '0);
    chk({nm, ".u1"},
        {bus1.gnt, bus1.busy, bus1.done, bus1.cand_sel,
         bus1.done_id, bus1.fitness, bus1.perfect}, '0);
    chk({nm, ".u1ops"},
        {bus1.a1, bus1.a0, bus1.b1, bus1.b0}, '0);
  endtask

  task automatic run_eval0(input int r, input int efit,
                           input string nm);
    bit seen;
    seen = 0;
    bus0.req = 3'(1 << r);
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) chk({nm, ".gnt"}, bus0.gnt, 3'(1 << r));
      if (bus0.done) begin
        seen = 1;
        chk({nm, ".lat"}, k, S0 + 6);
        chk({nm, ".fit"}, bus0.fitness, efit);
        chk({nm, ".perf"}, bus0.perfect, efit == 64);
        chk({nm, ".id"}, bus0.done_id, r);
      end
    end
    if (!seen) chk({nm, ".timeout"}, 0, 1);
    bus0.req = '0;
    @(negedge clk);
    chk({nm, ".after"}, {bus0.busy, bus0.done}, 2'b00);
  endtask

  vec_t tbl [7];

  int md, mg, mptr, efit, mid, nd;
  logic [6:0] mfit;
  logic       mperf;
  logic [N0-1:0] rq;
  bit seen;

  initial begin
    rst_n    = 1'b0;
    bus0.req = '0;
    bus1.req = '0;

    for (int i = 0; i < 16; i++) begin
      ea0[i] = 1'(i % 2);
      ea1[i] = 1'((i / 2) % 2);
      eb0[i] = 1'((i / 4) % 2);
      eb1[i] = 1'((i / 8) % 2);
      for (int k = 0; k < 4; k++) begin
        gold[k][i] = 1'((((i % 4) * (i / 4)) >> k) & 1);
      end
    end
    for (int r = 0; r < N0; r++) rand_cand(r);
    for (int r = 0; r < N1; r++)
      for (int k = 0; k < 4; k++) cw1[r][k] = 16'h0000;

    // G words carry 14 ones in total
    tbl[0] = '{16'hA0A0, 16'h6AC0, 16'h4C00, 16'h8000, 64};
    tbl[1] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 50};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 14};
    tbl[3] = '{16'h5F5F, 16'h953F, 16'hB3FF, 16'h7FFF, 0};
    tbl[4] = '{16'hA0A1, 16'h6AC0, 16'h4C00, 16'h8000, 63};
    tbl[5] = '{16'hA0A0, 16'h6AC0, 16'h4C00, 16'h0000, 63};
    tbl[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 51};

    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      set0(0, tbl[v].w0, tbl[v].w1, tbl[v].w2, tbl[v].w3);
      run_eval0(0, tbl[v].fit, $sformatf("tbl%0d", v));
    end

    // two requesters held together alternate from ptr 0
    do_reset;
    set0(0, gold[0], gold[1], gold[2], gold[3]);
    set0(1, 16'h0, 16'h0, 16'h0, 16'h0);
    bus0.req = 3'b011;
    nd = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c == 1)  chk("rr.gnt1", bus0.gnt, 3'b001);
      if (c == 9)  chk("rr.gnt9", bus0.gnt, 3'b010);
      if (c == 17) chk("rr.gnt17", bus0.gnt, 3'b001);
      if (bus0.done) begin
        if (nd < 3) begin
          chk("rr.cyc", c, 7 + 8 * nd);
          chk("rr.id", bus0.done_id, nd % 2);
          chk("rr.fit", bus0.fitness, (nd % 2) ? 50 : 64);
        end
        nd++;
      end
    end
    chk("rr.count", nd, 3);

    // reset during CMP2 abandons the evaluation
    do_reset;
    set0(0, gold[0], gold[1], gold[2], gold[3]);
    run_eval0(0, 64, "pre");
    bus0.req = 3'b011;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) chk("mid.gnt", bus0.gnt, 3'b010);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("mid.rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid.nodone", {bus0.done, bus0.busy}, 2'b00);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.regnt", bus0.gnt, 3'b001);
    bus0.req = 3'b001;
    seen = 0;
    for (int c = 2; c <= 30 && !seen; c++) begin
      @(negedge clk);
      if (bus0.done) begin
        seen = 1;
        chk("mid.id", bus0.done_id, 0);
        chk("mid.fit", bus0.fitness, 64);
      end
    end
    if (!seen) chk("mid.timeout", 0, 1);
    bus0.req = '0;

    // longer settle, request dropped while operands are held
    do_reset;
    bus1.req = 2'b10;
    nd = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) chk("set.gnt", bus1.gnt, 2'b10);
      if (c == 2) bus1.req = '0;
      if (c <= S1 + 1)
        chk("set.ops", {bus1.a1, bus1.a0, bus1.b1, bus1.b0},
            {ea1, ea0, eb1, eb0});
      if (c == S1 + 2)
        chk("set.opsoff", {bus1.a1, bus1.a0, bus1.b1, bus1.b0}, '0);
      if (bus1.done) begin
        nd++;
        chk("set.cyc", c, 9);
        chk("set.fit", bus1.fitness, 50);
        chk("set.id", bus1.done_id, 1);
      end
    end
    chk("set.count", nd, 1);

    // randomized traffic against the timeline model
    for (int r = 0; r < N0; r++) rand_cand(r);
    do_reset;
    md = 0;
    mg = 0;
    mptr = 0;
    mid = 0;
    efit = 0;
    mfit = '0;
    mperf = 1'b0;
    rq = '0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clk);
      if (md == S0 + 6) begin
        mfit  = 7'(efit);
        mperf = (efit == 64);
        mid   = mg;
      end
      chk("r.busy", bus0.busy, md != 0);
      chk("r.done", bus0.done, md == S0 + 6);
      if (md != S0 + 6)
        chk("r.gnt", bus0.gnt, (md != 0) ? 3'(1 << mg) : 3'b000);
      chk("r.ops", {bus0.a1, bus0.a0, bus0.b1, bus0.b0},
          (md >= 1 && md <= S0 + 1) ? {ea1, ea0, eb1, eb0} : 64'h0);
      if (md != 0) chk("r.sel", bus0.cand_sel, mg);
      chk("r.fit", bus0.fitness, mfit);
      chk("r.perf", bus0.perfect, mperf);
      chk("r.id", bus0.done_id, mid);

      if (md == S0 + 6) begin
        rq[mg] = 1'b0;
        rand_cand(mg);
        mptr = (mg + 1) % N0;
      end
      if (md >= 1 && md < S0 + 6 && $urandom_range(0, 7) == 0)
        rq[mg] = 1'b0;
      for (int r = 0; r < N0; r++)
        if (!rq[r] && $urandom_range(0, 2) == 0) rq[r] = 1'b1;
      bus0.req = rq;

      if (md == 0) begin
        if (rq != 0) begin
          seen = 0;
          for (int k = 0; k < N0; k++) begin
            if (!seen && rq[(mptr + k) % N0]) begin
              seen = 1;
              mg = (mptr + k) % N0;
            end
          end
          efit = ref_fit(cw0[mg][0], cw0[mg][1],
                         cw0[mg][2], cw0[mg][3]);
          md = 1;
        end
      end else if (md == S0 + 6) begin
        md = 0;
      end else begin
        md++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
